// File: rtl/match_event_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger_if
// Purpose  : Bundles the match-event logger's control inputs and status/readout
//            outputs so the detector side and the reader side share one port.
// Ports    : detector, clr, rd_en           -> into the logger
//            ts_data, ts_valid, fifo_full,
//            match_count, alarm, overflow   <- out of the logger
// Modports : master = driver/reader side, slave = logger side
// Revision : 1.0 - initial release
// ============================================================================
interface match_event_logger_if #(
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 detector;
  logic                 clr;
  logic                 rd_en;
  logic [TS_WIDTH-1:0]  ts_data;
  logic                 ts_valid;
  logic                 fifo_full;
  logic [CNT_WIDTH-1:0] match_count;
  logic                 alarm;
  logic                 overflow;

  modport master (
    output detector, clr, rd_en,
    input  ts_data, ts_valid, fifo_full, match_count, alarm, overflow
  );

  modport slave (
    input  detector, clr, rd_en,
    output ts_data, ts_valid, fifo_full, match_count, alarm, overflow
  );
endinterface
`default_nettype wire

// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger
// Purpose  : Timestamps rising edges of the sequence detector's match pulse,
//            keeps a saturating match count with a sticky threshold alarm, and
//            buffers timestamps in a first-word-fall-through FIFO.
// Ports    : clk   - rising-edge clock
//            rstn  - asynchronous active-low reset
//            bus   - match_event_logger_if.slave (detector/clr/rd_en in,
//                    ts_data/ts_valid/fifo_full/match_count/alarm/overflow out)
// Revision : 1.0 - initial release
// ============================================================================
module match_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int THRESHOLD = 8
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  match_event_logger_if.slave  bus
);

  localparam int                   c_aw        = $clog2(DEPTH);
  localparam logic [c_aw:0]        c_ptr_one   = (c_aw + 1)'(1);
  localparam logic [TS_WIDTH-1:0]  c_ts_one    = TS_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_thresh_m1 = CNT_WIDTH'(THRESHOLD - 1);

  logic [TS_WIDTH-1:0]  r_ts;
  logic                 r_det_q;
  logic [c_aw:0]        r_wr_ptr;
  logic [c_aw:0]        r_rd_ptr;
  logic [TS_WIDTH-1:0]  r_mem [DEPTH];
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_alarm;
  logic                 r_overflow;

  logic w_ev;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A held-high detector produces one event, on its first high cycle only.
  assign w_ev    = bus.detector & ~r_det_q;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  // A pop frees the slot the coincident write needs, so a full FIFO can
  // accept a write only when it is also being read.
  assign w_pop   = bus.rd_en & ~w_empty;
  assign w_push  = w_ev & (~w_full | w_pop);
  assign w_drop  = w_ev & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ts       <= '0;
      r_det_q    <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_alarm    <= 1'b0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Timestamp and edge-detect history run regardless of clr.
      r_ts    <= r_ts + c_ts_one;
      r_det_q <= bus.detector;

      if (bus.clr) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_alarm    <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
        if (w_push) begin
          r_mem[r_wr_ptr[c_aw-1:0]] <= r_ts;
          r_wr_ptr                  <= r_wr_ptr + c_ptr_one;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_ev && (r_count != c_cnt_max)) begin
          r_count <= r_count + c_cnt_one;
          // Alarm on the increment that lands exactly on the threshold.
          if (r_count == c_thresh_m1) begin
            r_alarm <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ts_data     = r_mem[r_rd_ptr[c_aw-1:0]];
  assign bus.ts_valid    = ~w_empty;
  assign bus.fifo_full   = w_full;
  assign bus.match_count = r_count;
  assign bus.alarm       = r_alarm;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_event_logger
// Purpose  : Self-checking bench for match_event_logger with a small
//            configuration (4-bit timestamp, 4-bit count, threshold 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_event_logger;

  localparam int TSW = 4;
  localparam int CW  = 4;
  localparam int DEP = 4;
  localparam int TH  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rstn;

  match_event_logger_if #(.TS_WIDTH(TSW), .CNT_WIDTH(CW)) bus ();

  match_event_logger #(
    .TS_WIDTH (TSW),
    .CNT_WIDTH(CW),
    .DEPTH    (DEP),
    .THRESHOLD(TH)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: timestamp is cycles since reset mod 2^TSW, FIFO is a queue.
  int  m_ts;
  bit  m_detq;
  int  m_cnt;
  bit  m_alarm;
  bit  m_ovf;
  int  m_q[$];

  typedef struct {
    bit d, c, r;
    int cnt;
    bit vld;
    int data;
    bit full, alarm, ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_detq = 0; m_cnt = 0; m_alarm = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit d, input bit c, input bit r);
    bit ev;
    ev = d && !m_detq;
    if (c) begin
      m_cnt = 0; m_alarm = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (r && m_q.size() > 0) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEP) m_q.push_back(m_ts);
        else                  m_ovf = 1;
        if (m_cnt < CMAX) begin
          m_cnt++;
          if (m_cnt == TH) m_alarm = 1;
        end
      end
    end
    m_detq = d;
    m_ts   = (m_ts + 1) % (1 << TSW);
  endtask

  task automatic model_compare();
    chk("mdl_ts_valid", int'(bus.ts_valid), int'(m_q.size() != 0));
    if (m_q.size() != 0) chk("mdl_ts_data", int'(bus.ts_data), m_q[0]);
    chk("mdl_fifo_full", int'(bus.fifo_full), int'(m_q.size() == DEP));
    chk("mdl_match_count", int'(bus.match_count), m_cnt);
    chk("mdl_alarm", int'(bus.alarm), int'(m_alarm));
    chk("mdl_overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input bit d, input bit c, input bit r);
    bus.detector = d; bus.clr = c; bus.rd_en = r;
    @(posedge clk);
    model_step(d, c, r);
    #1;
    model_compare();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ts_valid"}, int'(bus.ts_valid), 0);
    chk({tag, "_fifo_full"}, int'(bus.fifo_full), 0);
    chk({tag, "_match_count"}, int'(bus.match_count), 0);
    chk({tag, "_alarm"}, int'(bus.alarm), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
    chk({tag, "_ts_data"}, int'(bus.ts_data), 0);
  endtask

  int ts_rec[5];

  initial begin
    rstn = 1'b0;
    bus.detector = 1'b0; bus.clr = 1'b0; bus.rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;

    // ---- basic event and level-vs-pulse, row index equals ts ----
    for (int i = 0; i < 5; i++) tbl.push_back('{0,0,0, 0,0,0, 0,0,0});
    tbl.push_back('{1,0,0, 1,1,5,  0,0,0});
    tbl.push_back('{0,0,1, 1,0,0,  0,0,0});
    for (int i = 0; i < 4; i++) tbl.push_back('{1,0,0, 2,1,7, 0,0,0});
    tbl.push_back('{0,0,0, 2,1,7,  0,0,0});
    tbl.push_back('{1,0,0, 3,1,7,  0,0,0});
    tbl.push_back('{0,0,1, 3,1,12, 0,0,0});
    tbl.push_back('{0,0,1, 3,0,0,  0,0,0});
    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d_cnt", i), int'(bus.match_count), tbl[i].cnt);
      chk($sformatf("tbl%0d_vld", i), int'(bus.ts_valid), int'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), int'(bus.ts_data), tbl[i].data);
      chk($sformatf("tbl%0d_full", i), int'(bus.fifo_full), int'(tbl[i].full));
      chk($sformatf("tbl%0d_alarm", i), int'(bus.alarm), int'(tbl[i].alarm));
      chk($sformatf("tbl%0d_ovf", i), int'(bus.overflow), int'(tbl[i].ovf));
    end

    // ---- full / overflow, no reads ----
    cycle(0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      ts_rec[k] = m_ts;
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      if (k == 3) chk("full_after_4th", int'(bus.fifo_full), 1);
      if (k == 3) chk("no_ovf_after_4th", int'(bus.overflow), 0);
    end
    chk("ovf_after_5th", int'(bus.overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_readback%0d", k), int'(bus.ts_data), ts_rec[k]);
      cycle(0, 0, 1);
    end
    chk("ovf_drained", int'(bus.ts_valid), 0);

    // ---- full with a coincident pop on the 5th event ----
    cycle(0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      ts_rec[k] = m_ts;
      cycle(1, 0, k == 4);
      cycle(0, 0, 0);
    end
    chk("pop_full_no_ovf", int'(bus.overflow), 0);
    chk("pop_full_still_full", int'(bus.fifo_full), 1);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("pop_readback%0d", k), int'(bus.ts_data), ts_rec[k]);
      cycle(0, 0, 1);
    end

    // ---- alarm and saturation ----
    cycle(0, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 0, 0);
      chk($sformatf("sat_cnt%0d", k), int'(bus.match_count), (k > CMAX) ? CMAX : k);
      chk($sformatf("sat_alarm%0d", k), int'(bus.alarm), int'(k >= TH));
      cycle(0, 0, 1);
    end

    // ---- clear priority with entries buffered and flags set ----
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 0);
      cycle(0, 0, 0);
    end
    chk("pre_clr_ovf", int'(bus.overflow), 1);
    chk("pre_clr_alarm", int'(bus.alarm), 1);
    cycle(1, 1, 1);
    chk("clr_cnt", int'(bus.match_count), 0);
    chk("clr_vld", int'(bus.ts_valid), 0);
    chk("clr_alarm", int'(bus.alarm), 0);
    chk("clr_ovf", int'(bus.overflow), 0);
    cycle(0, 0, 0);
    ts_rec[0] = m_ts;
    cycle(1, 0, 0);
    chk("clr_ts_running", int'(bus.ts_data), ts_rec[0]);

    // ---- timestamp wrap ----
    cycle(0, 1, 0);
    while (m_ts != 14) cycle(0, 0, 0);
    cycle(1, 0, 0);
    while (m_ts != 1) cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("wrap_first", int'(bus.ts_data), 14);
    cycle(0, 0, 1);
    chk("wrap_second", int'(bus.ts_data), 1);

    // ---- asynchronous reset mid-burst ----
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    #2;
    rstn = 1'b0;
    bus.detector = 1'b0; bus.clr = 1'b0; bus.rd_en = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 2) == 0,
            $urandom_range(0, 60) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
